// File: rtl/ps2_key_receiver.sv
// rtl/ps2_key_receiver.sv - PS/2 keyboard receiver with scan-code decode and event FIFO
// Optional feature macro: PS2_PARITY_CHECK_EN (enforce odd parity; otherwise parity is ignored).
// Ports:
//   clock27, reset               : only clock; synchronous active-high reset
//   keyboardClock, keyboardData  : raw asynchronous PS/2 lines
//   key_valid, key_ready         : show-ahead event FIFO handshake
//   key_code, key_class, key_value : head event scan byte and its translation
//   key_release, key_extended    : head event carried F0 / E0 prefix
//   frame_error                  : one-cycle pulse on bad frame or inter-edge timeout
//   overflow                     : sticky, an event was dropped on a full FIFO
module ps2_key_receiver #(
  parameter int FIFO_DEPTH     = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 27000,
  parameter bit REPORT_BREAK   = 1'b0
) (
  input  logic       clock27,
  input  logic       reset,
  input  logic       keyboardClock,
  input  logic       keyboardData,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [7:0] key_code,
  output logic [1:0] key_class,
  output logic [3:0] key_value,
  output logic       key_release,
  output logic       key_extended,
  output logic       frame_error,
  output logic       overflow
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // Line synchronisers; idle-high reset value avoids a spurious edge after reset.
  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic clk_prev, fall, din;

  always_ff @(posedge clock27) begin
    if (reset) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], keyboardClock};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], keyboardData};
      clk_prev <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign fall = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign din  = dat_sync[SYNC_STAGES-1];

  // Frame FSM
  state_t        state, state_next;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic [TW-1:0] tcount;
  logic          frame_ok, frame_bad, parity_ok;
  logic          rx_valid;
  logic [7:0]    rx_byte;

`ifdef PS2_PARITY_CHECK_EN
  logic parity_bit;
  always_ff @(posedge clock27) begin
    if (reset) parity_bit <= 1'b0;
    else if (fall && state == PARITY) parity_bit <= din;
  end
  assign parity_ok = ^{shift, parity_bit};
`else
  assign parity_ok = 1'b1;
`endif

  always_ff @(posedge clock27) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    frame_ok   = 1'b0;
    frame_bad  = 1'b0;
    if (state == IDLE) begin
      if (fall && !din) state_next = DATA;
    end else if (fall) begin
      // A falling edge always wins over a simultaneous timeout.
      case (state)
        DATA:    if (bit_cnt == 3'd7) state_next = PARITY;
        PARITY:  state_next = STOP;
        STOP: begin
          state_next = IDLE;
          if (din && parity_ok) frame_ok  = 1'b1;
          else                  frame_bad = 1'b1;
        end
        default: state_next = IDLE;
      endcase
    end else if (tcount == TW'(TIMEOUT_CYCLES - 1)) begin
      state_next = IDLE;
      frame_bad  = 1'b1;
    end
  end

  always_ff @(posedge clock27) begin
    if (reset) begin
      bit_cnt     <= '0;
      shift       <= '0;
      tcount      <= '0;
      rx_valid    <= 1'b0;
      rx_byte     <= '0;
      frame_error <= 1'b0;
    end else begin
      rx_valid    <= frame_ok;
      frame_error <= frame_bad;
      if (frame_ok) rx_byte <= shift;
      if (state == IDLE || fall) tcount <= '0;
      else                       tcount <= tcount + 1'b1;
      if (state == IDLE) begin
        bit_cnt <= '0;
      end else if (fall && state == DATA) begin
        shift   <= {din, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  // Prefix decoder and scan-code translation
  logic       ext_flag, brk_flag, ev_fire, ev_keep;
  logic [1:0] ev_class;
  logic [3:0] ev_value;

  always_comb begin
    ev_class = 2'd3;
    ev_value = 4'hF;
    if (rx_byte == 8'h5A) begin
      ev_class = 2'd2;
      ev_value = 4'hA;
    end else if (!ext_flag) begin
      case (rx_byte)
        8'h1C: {ev_class, ev_value} = {2'd0, 4'd0};
        8'h32: {ev_class, ev_value} = {2'd0, 4'd1};
        8'h21: {ev_class, ev_value} = {2'd0, 4'd2};
        8'h23: {ev_class, ev_value} = {2'd0, 4'd3};
        8'h24: {ev_class, ev_value} = {2'd0, 4'd4};
        8'h2B: {ev_class, ev_value} = {2'd0, 4'd5};
        8'h34: {ev_class, ev_value} = {2'd0, 4'd6};
        8'h33: {ev_class, ev_value} = {2'd0, 4'd7};
        8'h43: {ev_class, ev_value} = {2'd0, 4'd8};
        8'h3B: {ev_class, ev_value} = {2'd0, 4'd9};
        8'h45: {ev_class, ev_value} = {2'd1, 4'd0};
        8'h16: {ev_class, ev_value} = {2'd1, 4'd1};
        8'h1E: {ev_class, ev_value} = {2'd1, 4'd2};
        8'h26: {ev_class, ev_value} = {2'd1, 4'd3};
        8'h25: {ev_class, ev_value} = {2'd1, 4'd4};
        8'h2E: {ev_class, ev_value} = {2'd1, 4'd5};
        8'h36: {ev_class, ev_value} = {2'd1, 4'd6};
        8'h3D: {ev_class, ev_value} = {2'd1, 4'd7};
        8'h3E: {ev_class, ev_value} = {2'd1, 4'd8};
        8'h46: {ev_class, ev_value} = {2'd1, 4'd9};
        default: ;
      endcase
    end
  end

  assign ev_fire = rx_valid && rx_byte != 8'hE0 && rx_byte != 8'hF0;
  assign ev_keep = ev_fire && (REPORT_BREAK || !brk_flag);

  always_ff @(posedge clock27) begin
    if (reset || frame_error) begin
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
    end else if (rx_valid) begin
      if (rx_byte == 8'hE0)      ext_flag <= 1'b1;
      else if (rx_byte == 8'hF0) brk_flag <= 1'b1;
      else begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end
    end
  end

  // Show-ahead event FIFO; a pop in the same cycle frees room for a push on full.
  logic [15:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   count;
  logic          do_pop, do_push;
  logic [15:0]   head;

  assign key_valid = (count != '0);
  assign do_pop    = key_valid && key_ready;
  assign do_push   = ev_keep && ((count != (PW+1)'(FIFO_DEPTH)) || do_pop);

  always_ff @(posedge clock27) begin
    if (do_push) mem[wr_ptr] <= {rx_byte, ev_class, ev_value, brk_flag, ext_flag};
  end

  always_ff @(posedge clock27) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (ev_keep && !do_push) overflow <= 1'b1;
    end
  end

  assign head = key_valid ? mem[rd_ptr] : '0;
  assign {key_code, key_class, key_value, key_release, key_extended} = head;
endmodule

// File: doc/ps2_key_receiver.md
# ps2_key_receiver

Parametrised PS/2 keyboard receiver running entirely in the `clock27` domain. It samples the keyboard's `keyboardClock`/`keyboardData` lines, frames 11-bit PS/2 packets, and checks start, stop and (optionally) parity bits. It resolves `E0`/`F0` prefix sequences and translates scan codes to letter/number/enter classes. Decoded key events are buffered in a FIFO behind a valid/ready handshake for the game logic.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: event FIFO entries; power of two, ≥2.
- `SYNC_STAGES`, 2: synchroniser flops on each PS/2 line, ≥2.
- `TIMEOUT_CYCLES`, 27000: `clock27` cycles allowed between falling edges inside a frame (1 ms at 27 MHz).
- `REPORT_BREAK`, 0: 1 = key-release events enter the FIFO; 0 = they are discarded.

Ports:
- `clock27` in 1: system clock; the only clock.
- `reset` in 1: synchronous, active-high reset.
- `keyboardClock` in 1: raw PS/2 clock, asynchronous.
- `keyboardData` in 1: raw PS/2 data, asynchronous.
- `key_valid` out 1: FIFO head holds an event.
- `key_ready` in 1: consumer accepts the head event.
- `key_code` out 8: raw final scan byte of the head event.
- `key_class` out 2: 0 letter, 1 number, 2 enter, 3 other.
- `key_value` out 4: letters A–J → 0–9; digits 0–9 → 0–9; enter → 4'hA; other → 4'hF.
- `key_release` out 1: head event is a break (`F0`-prefixed).
- `key_extended` out 1: head event was `E0`-prefixed.
- `frame_error` out 1: one-cycle pulse on a bad frame or timeout.
- `overflow` out 1: sticky; set when an event is dropped on a full FIFO.

## Operation
- Both lines pass through `SYNC_STAGES` flops. A falling edge is synced clock 1→0 between consecutive cycles, and data is sampled from the synced data line in the same cycle.
- Frame FSM states:
  - IDLE: on a falling edge with data=0, go to DATA with bit count 0; data=1 is ignored.
  - DATA: shift in 8 bits, LSB first; after the 8th bit, go to PARITY.
  - PARITY: capture the parity bit; go to STOP.
  - STOP: if stop=1 and the frame is valid, emit the byte to the decoder; otherwise pulse `frame_error`. Return to IDLE in either case.
- Timeout:
  - Counter clears on every falling edge and in IDLE.
  - In any non-IDLE state, reaching `TIMEOUT_CYCLES-1` aborts to IDLE and pulses `frame_error`; the partial byte is lost.
- Decoder holds two flags, `ext` and `brk`:
  - byte `E0` sets `ext`; byte `F0` sets `brk`; neither produces an event.
  - Any other byte forms an event with the current flags, then both flags clear.
  - Break events with `REPORT_BREAK`=0 are dropped silently, with no overflow.
  - A `frame_error` clears both flags.
- Translation:
  - Letters: 1C,32,21,23,24,2B,34,33,43,3B → class 0, values 0–9.
  - Digits: 45,16,1E,26,25,2E,36,3D,3E,46 → class 1, values 0–9.
  - Enter: 5A → class 2, value A; this applies with or without `ext`.
  - Any other byte, or any byte with `ext` set other than 5A → class 3, value F.
- FIFO:
  - Show-ahead: outputs always reflect the head entry, and `key_valid` = not empty.
  - Pop when `key_valid && key_ready`.
  - Push when full: the event is dropped and `overflow` sets.
  - Exception: if a pop occurs in the same cycle, the push is accepted and no overflow occurs.
  - Read and write pointers wrap modulo `FIFO_DEPTH`.

## Timing
- Reset values: `key_valid`, `key_release`, `key_extended`, `frame_error`, `overflow` = 0; `key_code` = 8'h00; `key_class` = 0; `key_value` = 0.
- Reset state: FSM IDLE, flags clear, FIFO empty, timeout counter 0.
- Reset mid-frame abandons the frame with no `frame_error`.
- Latency: stop-bit edge detected in cycle T → event registered in T+1 → FIFO write at end of T+1 → `key_valid` high in T+2 (empty FIFO case).
- `frame_error` is high for exactly one cycle, in the cycle after the failing stop edge or timeout.
- `overflow` clears only on `reset`.
- Output fields change only on a pop, or on a push into an empty FIFO.

## Configuration
- `PS2_PARITY_CHECK_EN` defined:
  - odd parity is enforced; the 8 data bits plus the parity bit must contain an odd number of 1s.
  - A mismatch pulses `frame_error` and drops the byte.
- Undefined: the parity bit is sampled and ignored; only start, stop and timeout errors are detected.

## Test plan
- Frame `1C` (parity 0, stop 1), `key_ready`=1 → one event: code 1C, class 0, value 0, release 0, extended 0; `key_valid` high 2 cycles after the stop edge.
- `16` then `F0`,`16` with `REPORT_BREAK`=0 → exactly one event (class 1, value 1). Same with `REPORT_BREAK`=1 → second event has `key_release`=1.
- `E0`,`5A` → class 2, value A, `key_extended`=1. Then `E0`,`75` → class 3, value F, `key_extended`=1.
- `1C` with parity bit 1 and macro defined → `frame_error` one-cycle pulse, no event. Same stimulus without the macro → event accepted.
- Start + 4 data bits, then idle for `TIMEOUT_CYCLES` → single `frame_error` pulse; the following clean `32` frame yields class 0, value 1.
- `key_ready`=0, send `FIFO_DEPTH`+1 letter frames → first `FIFO_DEPTH` retained in order, `overflow`=1. Draining yields them in order, then `key_valid`=0, with `overflow` still 1 until `reset`.
